cache_ctrl_burst: RTL and testbench
===================================

CACHE_CTRL_BURST -- requirements
Module: cache_ctrl_burst

Interface
REQ-001 Parameter BEATS_PER_LINE, default 4, memory beats per cache line (>=1).
REQ-002 Parameter WRITE_POLICY, default 0, 0=write-back, 1=write-through.
REQ-003 Parameter BW, default $clog2(BEATS_PER_LINE) (min 1), beat index width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 req_valid  in  1  CPU request present.
REQ-007 req_type  in  1  0=read, 1=write.
REQ-008 hit  in  1  tag match for current request (from tag array).
REQ-009 dirty_bit  in  1  victim line dirty.
REQ-010 ready_mem  in  1  memory accepts/returns one beat this cycle.
REQ-011 read_en_mem  out  1  memory line-fill read request.
REQ-012 write_en_mem  out  1  memory write request (writeback beat or write-through word).
REQ-013 write_en  out  1  CPU word write into cache data array.
REQ-014 read_en_cache  out  1  victim beat read from cache for writeback.
REQ-015 write_en_cache  out  1  refill beat write into cache.
REQ-016 refill  out  1  line refill complete, tag/valid update strobe.
REQ-017 done_cache  out  1  request completed, one-cycle pulse.
REQ-018 beat_idx  out  BW  current beat within line burst.
REQ-019 busy  out  1  high whenever state != IDLE.

Function
REQ-020 States: IDLE, COMPARE, WRITE_BACK, WRITE_ALLOCATE, REFILL_DONE, WT_WRITE; outputs decoded from state plus same-cycle inputs, no output registers.
REQ-021 IDLE: req_valid=1 -> COMPARE next cycle; otherwise hold; ready_mem, hit, dirty_bit ignored.
REQ-022 COMPARE, hit, read: done_cache=1 this cycle; -> IDLE.
REQ-023 COMPARE, hit, write, WRITE_POLICY=0: write_en=1, done_cache=1 this cycle; -> IDLE.
REQ-024 COMPARE, hit, write, WRITE_POLICY=1: write_en=1 this cycle; -> WT_WRITE.
REQ-025 WT_WRITE: write_en_mem=1 until ready_mem=1; on that cycle done_cache=1, -> IDLE.
REQ-026 COMPARE, miss: dirty_bit=1 and WRITE_POLICY=0 -> WRITE_BACK; else -> WRITE_ALLOCATE; beat_idx cleared to 0.
REQ-027 WRITE_POLICY=1: dirty_bit ignored, WRITE_BACK unreachable.
REQ-028 WRITE_BACK: read_en_cache=1, write_en_mem=1 every cycle; ready_mem=1 advances beat_idx; ready_mem=1 with beat_idx=BEATS_PER_LINE-1 -> WRITE_ALLOCATE, beat_idx to 0.
REQ-029 WRITE_ALLOCATE: read_en_mem=1 every cycle; ready_mem=1 gives write_en_cache=1 same cycle and advances beat_idx; last beat accepted -> REFILL_DONE, beat_idx to 0.
REQ-030 REFILL_DONE: refill=1 for exactly one cycle; -> COMPARE (request re-evaluated, hit expected).
REQ-031 ready_mem=0 stalls burst states indefinitely with beat_idx and request outputs held.
REQ-032 BEATS_PER_LINE=1: each burst completes on first ready_mem=1; beat_idx stays 0.
REQ-033 req_valid/req_type changes after IDLE are ignored until IDLE is re-entered; req_type sampled in COMPARE.
REQ-034 Never asserted together: read_en_mem with write_en_mem; write_en_cache with read_en_cache.
REQ-035 done_cache never asserted outside COMPARE or WT_WRITE.

Reset
REQ-036 rst=0 at clock edge: state=IDLE, beat_idx=0, all outputs 0 next cycle, including mid-burst.
REQ-037 First request accepted on first edge after rst returns high.

Structure
REQ-038 Package cache_ctrl_pkg holds state_t (logic [3:0] enum, order as REQ-020) and WB/WT policy constants.
REQ-039 Sub-module cache_beat_counter (clear, advance, last-beat flag) instantiated once.

Verification
REQ-040 Read miss clean, BEATS=4, ready_mem=1: IDLE,COMPARE, 4 cycles read_en_mem+write_en_cache beat 0..3, refill=1, COMPARE with hit=1 -> done_cache=1, IDLE.
REQ-041 Write miss dirty, WB, BEATS=4, ready_mem toggling 1/0: write_en_mem+read_en_cache 4 accepted beats, then 4 refill beats, refill, write_en=1+done_cache=1.
REQ-042 Write hit, WT, ready_mem low 3 cycles: write_en=1 in COMPARE, write_en_mem=1 for 4 cycles, done_cache=1 on ready.
REQ-043 Reset at beat 2 of WRITE_ALLOCATE: next cycle state IDLE, beat_idx=0, all outputs 0.
REQ-044 BEATS=1, read miss dirty WB: one writeback beat, one refill beat, refill pulse, done on hit.
REQ-045 Every scenario checks REQ-034 exclusivity and busy==(state!=IDLE) each cycle.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the burst cache controller.
package cache_ctrl_pkg;

  // Controller states, encoded in declaration order.
  typedef enum logic [3:0] {
    ST_IDLE           = 4'd0,
    ST_COMPARE        = 4'd1,
    ST_WRITE_BACK     = 4'd2,
    ST_WRITE_ALLOCATE = 4'd3,
    ST_REFILL_DONE    = 4'd4,
    ST_WT_WRITE       = 4'd5
  } state_t;

  // Write policy selectors.
  localparam int unsigned WP_WRITE_BACK    = 0;
  localparam int unsigned WP_WRITE_THROUGH = 1;

  // Beat index width; a single-beat line still gets one bit.
  function automatic int unsigned beat_idx_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/cache_beat_counter.sv
// Beat counter for line bursts: synchronous clear, advance, last-beat flag.
module cache_beat_counter #(
  parameter int unsigned BEATS_PER_LINE = 4,
  parameter int unsigned BW             = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [BW-1:0] idx,
  output logic          last
);

  // Last beat of the line burst.
  always_comb begin
    last = (idx == BW'(BEATS_PER_LINE - 1));
  end

  // Count accepted beats; wraps to zero after the last beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (advance) begin
      idx <= last ? '0 : idx + BW'(1);
    end
  end

endmodule

// File: rtl/cache_ctrl_burst.sv
// Cache controller with line-burst writeback/refill and selectable write policy.
// Outputs are decoded from the current state and same-cycle inputs.
module cache_ctrl_burst
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned BEATS_PER_LINE = 4,
  parameter int unsigned WRITE_POLICY   = WP_WRITE_BACK,
  parameter int unsigned BW             = beat_idx_width(BEATS_PER_LINE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_type,
  input  logic          hit,
  input  logic          dirty_bit,
  input  logic          ready_mem,
  output logic          read_en_mem,
  output logic          write_en_mem,
  output logic          write_en,
  output logic          read_en_cache,
  output logic          write_en_cache,
  output logic          refill,
  output logic          done_cache,
  output logic [BW-1:0] beat_idx,
  output logic          busy
);

  localparam bit POLICY_WB = (WRITE_POLICY == WP_WRITE_BACK);

  state_t state;
  state_t next_state;
  logic   cnt_clear;
  logic   cnt_advance;
  logic   cnt_last;

  // Beat position within the current writeback or refill burst.
  cache_beat_counter #(
    .BEATS_PER_LINE (BEATS_PER_LINE),
    .BW             (BW)
  ) u_beat_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .idx     (beat_idx),
    .last    (cnt_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode.
  always_comb begin
    next_state     = state;
    read_en_mem    = 1'b0;
    write_en_mem   = 1'b0;
    write_en       = 1'b0;
    read_en_cache  = 1'b0;
    write_en_cache = 1'b0;
    refill         = 1'b0;
    done_cache     = 1'b0;
    cnt_clear      = 1'b0;
    cnt_advance    = 1'b0;
    busy           = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          next_state = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        // Every burst starts from beat zero.
        cnt_clear = 1'b1;
        if (hit) begin
          if (req_type) begin
            write_en = 1'b1;
            if (POLICY_WB) begin
              done_cache = 1'b1;
              next_state = ST_IDLE;
            end else begin
              next_state = ST_WT_WRITE;
            end
          end else begin
            done_cache = 1'b1;
            next_state = ST_IDLE;
          end
        end else if (POLICY_WB && dirty_bit) begin
          next_state = ST_WRITE_BACK;
        end else begin
          next_state = ST_WRITE_ALLOCATE;
        end
      end

      ST_WRITE_BACK: begin
        read_en_cache = 1'b1;
        write_en_mem  = 1'b1;
        if (ready_mem) begin
          cnt_advance = 1'b1;
          if (cnt_last) begin
            next_state = ST_WRITE_ALLOCATE;
          end
        end
      end

      ST_WRITE_ALLOCATE: begin
        read_en_mem = 1'b1;
        if (ready_mem) begin
          write_en_cache = 1'b1;
          cnt_advance    = 1'b1;
          if (cnt_last) begin
            next_state = ST_REFILL_DONE;
          end
        end
      end

      ST_REFILL_DONE: begin
        // Line is now resident; re-run the lookup for the held request.
        refill     = 1'b1;
        next_state = ST_COMPARE;
      end

      ST_WT_WRITE: begin
        write_en_mem = 1'b1;
        if (ready_mem) begin
          done_cache = 1'b1;
          next_state = ST_IDLE;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Memory and cache data-port strobes are mutually exclusive.
  a_mem_excl : assert property (@(posedge clk) disable iff (!rst)
    !(read_en_mem && write_en_mem));
  a_cache_excl : assert property (@(posedge clk) disable iff (!rst)
    !(write_en_cache && read_en_cache));
  // Completion only comes from lookup or write-through drain.
  a_done_src : assert property (@(posedge clk) disable iff (!rst)
    done_cache |-> (state == ST_COMPARE || state == ST_WT_WRITE));

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// Directed self-checking bench for cache_ctrl_burst: three instances cover
// write-back/4 beats, write-through/4 beats and write-back/1 beat.
module tb_cache_ctrl_burst;

  logic clk;
  logic rst;
  logic req_type, hit, dirty_bit, ready_mem;
  logic req_valid_wb, req_valid_wt, req_valid_b1;

  logic       rem_wb, wem_wb, we_wb, rec_wb, wec_wb, rf_wb, dn_wb, bz_wb;
  logic       rem_wt, wem_wt, we_wt, rec_wt, wec_wt, rf_wt, dn_wt, bz_wt;
  logic       rem_b1, wem_b1, we_b1, rec_b1, wec_b1, rf_b1, dn_b1, bz_b1;
  logic [1:0] beat_wb, beat_wt;
  logic [0:0] beat_b1;

  logic [7:0] ov_wb, ov_wt, ov_b1;
  assign ov_wb = {rem_wb, wem_wb, we_wb, rec_wb, wec_wb, rf_wb, dn_wb, bz_wb};
  assign ov_wt = {rem_wt, wem_wt, we_wt, rec_wt, wec_wt, rf_wt, dn_wt, bz_wt};
  assign ov_b1 = {rem_b1, wem_b1, we_b1, rec_b1, wec_b1, rf_b1, dn_b1, bz_b1};

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  cache_ctrl_burst #(.BEATS_PER_LINE(4), .WRITE_POLICY(0)) dut_wb (
    .clk(clk), .rst(rst), .req_valid(req_valid_wb), .req_type(req_type),
    .hit(hit), .dirty_bit(dirty_bit), .ready_mem(ready_mem),
    .read_en_mem(rem_wb), .write_en_mem(wem_wb), .write_en(we_wb),
    .read_en_cache(rec_wb), .write_en_cache(wec_wb), .refill(rf_wb),
    .done_cache(dn_wb), .beat_idx(beat_wb), .busy(bz_wb));

  cache_ctrl_burst #(.BEATS_PER_LINE(4), .WRITE_POLICY(1)) dut_wt (
    .clk(clk), .rst(rst), .req_valid(req_valid_wt), .req_type(req_type),
    .hit(hit), .dirty_bit(dirty_bit), .ready_mem(ready_mem),
    .read_en_mem(rem_wt), .write_en_mem(wem_wt), .write_en(we_wt),
    .read_en_cache(rec_wt), .write_en_cache(wec_wt), .refill(rf_wt),
    .done_cache(dn_wt), .beat_idx(beat_wt), .busy(bz_wt));

  cache_ctrl_burst #(.BEATS_PER_LINE(1), .WRITE_POLICY(0)) dut_b1 (
    .clk(clk), .rst(rst), .req_valid(req_valid_b1), .req_type(req_type),
    .hit(hit), .dirty_bit(dirty_bit), .ready_mem(ready_mem),
    .read_en_mem(rem_b1), .write_en_mem(wem_b1), .write_en(we_b1),
    .read_en_cache(rec_b1), .write_en_cache(wec_b1), .refill(rf_b1),
    .done_cache(dn_b1), .beat_idx(beat_b1), .busy(bz_b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe exclusivity on every instance, every cycle after reset.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((ov_wb[7] & ov_wb[6]) | (ov_wb[3] & ov_wb[4])) begin
        failures++;
        $display("FAIL excl_wb t=%0t out=%b", $time, ov_wb);
      end
      checks++;
      if ((ov_wt[7] & ov_wt[6]) | (ov_wt[3] & ov_wt[4])) begin
        failures++;
        $display("FAIL excl_wt t=%0t out=%b", $time, ov_wt);
      end
      checks++;
      if ((ov_b1[7] & ov_b1[6]) | (ov_b1[3] & ov_b1[4])) begin
        failures++;
        $display("FAIL excl_b1 t=%0t out=%b", $time, ov_b1);
      end
    end
  end

  // Vector bits: {rst, req_valid, req_type, hit, dirty_bit, ready_mem}.
  task automatic drive(input int sel, input logic [5:0] v);
    rst          = v[5];
    req_valid_wb = (sel == 0) && v[4];
    req_valid_wt = (sel == 1) && v[4];
    req_valid_b1 = (sel == 2) && v[4];
    req_type     = v[3];
    hit          = v[2];
    dirty_bit    = v[1];
    ready_mem    = v[0];
  endtask

  task automatic test_reset();
    drive(0, 6'b000000);
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (ov_wb !== 8'h00 || beat_wb !== 2'd0 || ov_wt !== 8'h00 || beat_wt !== 2'd0 ||
          ov_b1 !== 8'h00 || beat_b1 !== 1'b0) begin
        failures++;
        $display("FAIL reset cyc=%0d wb=%b/%0d wt=%b/%0d b1=%b/%0d want all zero",
                 c, ov_wb, beat_wb, ov_wt, beat_wt, ov_b1, beat_b1);
      end
      @(posedge clk); #1;
    end
    mon_en = 1'b1;
  endtask

  task automatic test_read_miss_clean();
    logic [5:0] iv [9] = '{6'b110001, 6'b100001, 6'b100001, 6'b100001, 6'b100001,
                           6'b100001, 6'b100001, 6'b100101, 6'b100000};
    logic [7:0] eo [9] = '{8'h00, 8'h01, 8'h89, 8'h89, 8'h89, 8'h89, 8'h05, 8'h03, 8'h00};
    logic [1:0] eb [9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
    for (int c = 0; c < 9; c++) begin
      drive(0, iv[c]);
      @(negedge clk);
      checks++;
      if (ov_wb !== eo[c] || beat_wb !== eb[c]) begin
        failures++;
        $display("FAIL read_miss_clean cyc=%0d out=%b beat=%0d want out=%b beat=%0d",
                 c, ov_wb, beat_wb, eo[c], eb[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write_miss_dirty();
    logic [5:0] iv [20] = '{6'b111010, 6'b101010,
                            6'b101011, 6'b101010, 6'b101011, 6'b101010,
                            6'b101011, 6'b101010, 6'b101011,
                            6'b101010, 6'b101011, 6'b101010, 6'b101011,
                            6'b101010, 6'b101011, 6'b101010, 6'b101011,
                            6'b101010, 6'b101110, 6'b100000};
    logic [7:0] eo [20] = '{8'h00, 8'h01,
                            8'h51, 8'h51, 8'h51, 8'h51, 8'h51, 8'h51, 8'h51,
                            8'h81, 8'h89, 8'h81, 8'h89, 8'h81, 8'h89, 8'h81, 8'h89,
                            8'h05, 8'h23, 8'h00};
    logic [1:0] eb [20] = '{2'd0, 2'd0,
                            2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3,
                            2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3,
                            2'd0, 2'd0, 2'd0};
    for (int c = 0; c < 20; c++) begin
      drive(0, iv[c]);
      @(negedge clk);
      checks++;
      if (ov_wb !== eo[c] || beat_wb !== eb[c]) begin
        failures++;
        $display("FAIL write_miss_dirty cyc=%0d out=%b beat=%0d want out=%b beat=%0d",
                 c, ov_wb, beat_wb, eo[c], eb[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wt_write_hit();
    logic [5:0] iv [7] = '{6'b111100, 6'b101100, 6'b101100, 6'b101100, 6'b101100,
                           6'b101101, 6'b100000};
    logic [7:0] eo [7] = '{8'h00, 8'h21, 8'h41, 8'h41, 8'h41, 8'h43, 8'h00};
    for (int c = 0; c < 7; c++) begin
      drive(1, iv[c]);
      @(negedge clk);
      checks++;
      if (ov_wt !== eo[c] || beat_wt !== 2'd0) begin
        failures++;
        $display("FAIL wt_write_hit cyc=%0d out=%b beat=%0d want out=%b beat=0",
                 c, ov_wt, beat_wt, eo[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wt_miss_dirty_ignored();
    logic [5:0] iv [9] = '{6'b110010, 6'b100011, 6'b100011, 6'b100011, 6'b100011,
                           6'b100011, 6'b100010, 6'b100100, 6'b100000};
    logic [7:0] eo [9] = '{8'h00, 8'h01, 8'h89, 8'h89, 8'h89, 8'h89, 8'h05, 8'h03, 8'h00};
    logic [1:0] eb [9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
    for (int c = 0; c < 9; c++) begin
      drive(1, iv[c]);
      @(negedge clk);
      checks++;
      if (ov_wt !== eo[c] || beat_wt !== eb[c]) begin
        failures++;
        $display("FAIL wt_miss_dirty cyc=%0d out=%b beat=%0d want out=%b beat=%0d",
                 c, ov_wt, beat_wt, eo[c], eb[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [5:0] iv [9] = '{6'b110001, 6'b100001, 6'b100001, 6'b100001, 6'b000001,
                           6'b100001, 6'b110000, 6'b100100, 6'b100000};
    logic [7:0] eo [9] = '{8'h00, 8'h01, 8'h89, 8'h89, 8'h89, 8'h00, 8'h00, 8'h03, 8'h00};
    logic [1:0] eb [9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    for (int c = 0; c < 9; c++) begin
      drive(0, iv[c]);
      @(negedge clk);
      checks++;
      if (ov_wb !== eo[c] || beat_wb !== eb[c]) begin
        failures++;
        $display("FAIL reset_mid_burst cyc=%0d out=%b beat=%0d want out=%b beat=%0d",
                 c, ov_wb, beat_wb, eo[c], eb[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_beat();
    logic [5:0] iv [8] = '{6'b110010, 6'b100010, 6'b100010, 6'b100011, 6'b100011,
                           6'b100000, 6'b100100, 6'b100000};
    logic [7:0] eo [8] = '{8'h00, 8'h01, 8'h51, 8'h51, 8'h89, 8'h05, 8'h03, 8'h00};
    for (int c = 0; c < 8; c++) begin
      drive(2, iv[c]);
      @(negedge clk);
      checks++;
      if (ov_b1 !== eo[c] || beat_b1 !== 1'b0) begin
        failures++;
        $display("FAIL single_beat cyc=%0d out=%b beat=%0d want out=%b beat=0",
                 c, ov_b1, beat_b1, eo[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] iv [5] = '{6'b110100, 6'b110100, 6'b111100, 6'b101100, 6'b100000};
    logic [7:0] eo [5] = '{8'h00, 8'h03, 8'h00, 8'h23, 8'h00};
    for (int c = 0; c < 5; c++) begin
      drive(0, iv[c]);
      @(negedge clk);
      checks++;
      if (ov_wb !== eo[c] || beat_wb !== 2'd0) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d out=%b beat=%0d want out=%b beat=0",
                 c, ov_wb, beat_wb, eo[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_read_miss_clean();
    test_write_miss_dirty();
    test_wt_write_hit();
    test_wt_miss_dirty_ignored();
    test_reset_mid_burst();
    test_single_beat();
    test_back_to_back();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
